// File: rtl/ps2_scancode_seq_if.sv
// Byte-in / event-out handshake bundle for the PS/2 scancode sequencer.
interface ps2_scancode_seq_if;
  logic [7:0] rxdata;
  logic       rxdata_valid;
  logic       rxdata_error;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_valid;
  logic       ev_ready;

  modport master (
    output rxdata, rxdata_valid, rxdata_error, ev_ready,
    input  ev_code, ev_ext, ev_release, ev_valid
  );

  modport slave (
    input  rxdata, rxdata_valid, rxdata_error, ev_ready,
    output ev_code, ev_ext, ev_release, ev_valid
  );
endinterface

// File: rtl/ps2_scancode_seq.sv
// Turns the PS/2 set-2 byte stream into make/break key events with E0/F0/E1
// prefix tracking, control-byte filtering, stall timeout and an event FIFO.
module ps2_scancode_seq #(
  parameter int unsigned CLK_FREQ    = 28000000,
  parameter int unsigned SEQ_TOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  ps2_scancode_seq_if.slave  bus,
  output logic               kbd_reset,
  output logic               seq_error,
  output logic               overflow,
  input  logic               overflow_clr
);

  localparam longint unsigned TOUT_TICKS =
    (longint'(SEQ_TOUT_US) * longint'(CLK_FREQ)) / 64'd1000000;
  localparam int unsigned TW = $clog2(TOUT_TICKS + 1);
  localparam logic [TW-1:0] TOUT_C = TW'(TOUT_TICKS);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_PAUSE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    pause_q, pause_d;
  logic          kbd_reset_q, kbd_reset_d;
  logic          seq_error_q, seq_error_d;

  logic          acc;
  logic          abort;
  logic          fake_shift;
  logic          push;
  logic [9:0]    push_data;

  assign acc        = bus.rxdata_valid & ~bus.rxdata_error;
  assign abort      = (state_q != S_IDLE) & (bus.rxdata_error | (timer_q == TOUT_C));
  assign fake_shift = (bus.rxdata == 8'h12) | (bus.rxdata == 8'h59);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      pause_q     <= '0;
      kbd_reset_q <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pause_q     <= pause_d;
      kbd_reset_q <= kbd_reset_d;
      seq_error_q <= seq_error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pause_d = pause_q;
    if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (acc) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.rxdata == 8'hE0) state_d = S_EXT;
          else if (bus.rxdata == 8'hF0) state_d = S_BRK;
          else if (bus.rxdata == 8'hE1) begin
            state_d = S_PAUSE;
            pause_d = 3'd7;
          end
        end
        S_EXT: begin
          if (bus.rxdata == 8'hF0) state_d = S_EXTBRK;
          else if (bus.rxdata != 8'hE0) state_d = S_IDLE;
        end
        S_BRK, S_EXTBRK: state_d = S_IDLE;
        S_PAUSE: begin
          pause_d = pause_q - 3'd1;
          if (pause_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      timer_d = (state_d != S_IDLE) ? TW'(1) : '0;
    end else if (state_q != S_IDLE) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end

  always_comb begin
    push        = 1'b0;
    push_data   = '0;
    kbd_reset_d = 1'b0;
    seq_error_d = abort;
    if (!abort && acc) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (bus.rxdata)
            8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hFA, 8'hEE, 8'hFE, 8'hFF: ;
            8'hAA, 8'hFC: kbd_reset_d = 1'b1;
            default: begin
              push      = 1'b1;
              push_data = {2'b00, bus.rxdata};
            end
          endcase
        end
        S_EXT: begin
          if (bus.rxdata != 8'hF0 && bus.rxdata != 8'hE0 && !fake_shift) begin
            push      = 1'b1;
            push_data = {2'b10, bus.rxdata};
          end
        end
        S_BRK: begin
          push      = 1'b1;
          push_data = {2'b01, bus.rxdata};
        end
        S_EXTBRK: begin
          if (!fake_shift) begin
            push      = 1'b1;
            push_data = {2'b11, bus.rxdata};
          end
        end
        S_PAUSE: begin
          if (pause_q == 3'd1) begin
            push      = 1'b1;
            push_data = {2'b10, 8'h77};
          end
        end
        default: ;
      endcase
    end
  end

  assign kbd_reset = kbd_reset_q;
  assign seq_error = seq_error_q;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          full, pop, do_push, ev_valid_w;
  logic [9:0]    head;

  assign ev_valid_w = (cnt_q != '0);
  assign full       = (cnt_q == DEPTH_C);
  assign pop        = ev_valid_w & bus.ev_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push    = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      if (do_push && !pop)      cnt_q <= cnt_q + (PW + 1)'(1);
      else if (!do_push && pop) cnt_q <= cnt_q - (PW + 1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

  assign head           = ev_valid_w ? mem[rptr_q] : '0;
  assign bus.ev_valid   = ev_valid_w;
  assign bus.ev_ext     = head[9];
  assign bus.ev_release = head[8];
  assign bus.ev_code    = head[7:0];

endmodule

// File: tb/tb_ps2_scancode_seq.sv
// Scoreboard bench: a prefix-level byte model predicts events and pulse counts;
// a negedge monitor pops and compares whenever the DUT hands over an event.
module tb_ps2_scancode_seq;
  localparam int unsigned CLK_FREQ    = 1000000;
  localparam int unsigned SEQ_TOUT_US = 20;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned TOUT        = SEQ_TOUT_US * CLK_FREQ / 1000000;

  logic clk = 1'b0;
  logic rst;
  logic kbd_reset, seq_error, overflow, overflow_clr;

  ps2_scancode_seq_if bus ();

  ps2_scancode_seq #(
    .CLK_FREQ   (CLK_FREQ),
    .SEQ_TOUT_US(SEQ_TOUT_US),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .kbd_reset   (kbd_reset),
    .seq_error   (seq_error),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  int kbd_exp = 0, seq_exp = 0, kbd_seen = 0, seq_seen = 0;
  int kbd_run = 0, seq_run = 0;
  bit m_ext, m_brk, drop_mode, rand_mode;
  int m_pause;
  bit ovf_exp;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      kbd_run = 0;
      seq_run = 0;
    end else begin
      if (bus.ev_valid && bus.ev_ready) begin
        if (exp_q.size() == 0) check("unexpected_event", exp_q.size(), 1);
        else check("event", {bus.ev_ext, bus.ev_release, bus.ev_code}, exp_q.pop_front());
      end
      if (kbd_reset) kbd_run++;
      else if (kbd_run != 0) begin
        check("kbd_reset_len", kbd_run, 1);
        kbd_seen++;
        kbd_run = 0;
      end
      if (seq_error) seq_run++;
      else if (seq_run != 0) begin
        check("seq_error_len", seq_run, 1);
        seq_seen++;
        seq_run = 0;
      end
    end
  end

  // Reference model: prefix flags plus a count of pause bytes still to swallow.
  function automatic bit m_idle();
    return !m_ext && !m_brk && (m_pause == 0);
  endfunction

  task automatic m_clear();
    m_ext = 0; m_brk = 0; m_pause = 0;
  endtask

  task automatic m_push(logic e, logic r, logic [7:0] c);
    if (drop_mode && exp_q.size() >= DEPTH) ovf_exp = 1'b1;
    else exp_q.push_back({e, r, c});
  endtask

  task automatic model_byte(logic [7:0] b);
    bit fake;
    fake = (b == 8'h12) || (b == 8'h59);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) m_push(1, 0, 8'h77);
    end else if (m_brk) begin
      if (!(m_ext && fake)) m_push(m_ext, 1, b);
      m_clear();
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        if (!fake) m_push(1, 0, b);
        m_clear();
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: m_pause = 7;
        8'hAA, 8'hFC: kbd_exp++;
        8'h00, 8'hFA, 8'hEE, 8'hFE, 8'hFF: ;
        default: m_push(0, 0, b);
      endcase
    end
  endtask

  task automatic set_ready();
    if (rand_mode) bus.ev_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(logic [7:0] b);
    @(posedge clk); #1;
    set_ready();
    bus.rxdata = b;
    bus.rxdata_valid = 1'b1;
    @(posedge clk); #1;
    bus.rxdata_valid = 1'b0;
    set_ready();
    model_byte(b);
  endtask

  task automatic send_err();
    @(posedge clk); #1;
    bus.rxdata = 8'($urandom);
    bus.rxdata_valid = 1'($urandom_range(0, 1));
    bus.rxdata_error = 1'b1;
    @(posedge clk); #1;
    bus.rxdata_valid = 1'b0;
    bus.rxdata_error = 1'b0;
    if (!m_idle()) seq_exp++;
    m_clear();
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_ready();
    end
  endtask

  task automatic expire();
    idle(TOUT + 5);
    if (!m_idle()) seq_exp++;
    m_clear();
  endtask

  task automatic drain(string name);
    int n = 0;
    bus.ev_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  logic [7:0] pool [18] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFC, 8'h00, 8'hFA, 8'hEE,
                            8'hFE, 8'hFF, 8'h12, 8'h59, 8'h1C, 8'h77, 8'h14, 8'h75,
                            8'h6B, 8'h7C};

  initial begin
    bus.rxdata = '0; bus.rxdata_valid = 1'b0; bus.rxdata_error = 1'b0;
    bus.ev_ready = 1'b1; overflow_clr = 1'b0;
    drop_mode = 0; rand_mode = 0; ovf_exp = 0;
    m_clear();
    rst = 1'b1;
    #12;
    check("reset_outputs", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_release,
                            kbd_reset, seq_error, overflow}, 0);
    @(negedge clk); rst = 1'b0;

    // single make, visible for exactly one cycle
    send(8'h1C);
    @(negedge clk);
    check("make_valid", bus.ev_valid, 1);
    check("make_head", {bus.ev_ext, bus.ev_release, bus.ev_code}, 10'h01C);
    @(negedge clk);
    check("make_one_cycle", bus.ev_valid, 0);

    // break and extended break, pause, fake shift
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    check("expected_events", exp_q.size() <= 4, 1);
    drain("drain_prefix");

    // stall timeout, then a clean make
    send(8'hE0);
    expire();
    idle(3);
    check("timeout_seq_error", seq_seen, seq_exp);
    send(8'h1C);
    // line error mid-sequence
    send(8'hF0);
    send_err();
    send(8'h1C);
    idle(3);
    check("linerr_seq_error", seq_seen, seq_exp);
    drain("drain_abort");

    // overflow
    bus.ev_ready = 1'b0;
    drop_mode = 1;
    for (int i = 1; i <= 5; i++) send(8'(i));
    @(negedge clk);
    check("ovf_valid", bus.ev_valid, 1);
    check("ovf_set", overflow, ovf_exp);
    drop_mode = 0;
    drain("drain_ovf");
    check("ovf_sticky", overflow, ovf_exp);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    ovf_exp = 0;
    check("ovf_clear", overflow, ovf_exp);

    // keyboard self-test reply
    send(8'hAA);
    idle(3);
    check("kbd_reset_count", kbd_seen, kbd_exp);
    check("kbd_no_event", bus.ev_valid, 0);

    // async reset mid-sequence with queued events
    bus.ev_ready = 1'b0;
    send(8'h1C); send(8'h2D); send(8'hE0); send(8'hF0);
    #3 rst = 1'b1;
    #1;
    check("reset_midseq", {bus.ev_valid, bus.ev_code, bus.ev_ext, bus.ev_release,
                           kbd_reset, seq_error, overflow}, 0);
    exp_q.delete();
    m_clear();
    @(negedge clk); rst = 1'b0;
    bus.ev_ready = 1'b1;
    send(8'h1C);
    drain("drain_after_reset");

    // randomized stream
    rand_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int n = 0;
      while (exp_q.size() >= 2 && n < 100) begin
        bus.ev_ready = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      if ($urandom_range(0, 29) == 0) send_err();
      else if ($urandom_range(0, 9) < 6) send(pool[$urandom_range(0, 17)]);
      else send(8'($urandom));
      idle($urandom_range(0, 3));
    end
    rand_mode = 0;
    expire();
    drain("drain_random");
    idle(4);
    check("rand_kbd_reset_count", kbd_seen, kbd_exp);
    check("rand_seq_error_count", seq_seen, seq_exp);
    check("rand_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
